// File: rtl/mult_pkg.sv
// Shared definitions for the approximate-multiplier slice: widths, latency and
// the accumulator FSM encoding.
package mult_pkg;

  localparam int PW_DEF   = 32;
  localparam int OPW      = 16;
  localparam int MULT_LAT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_e;

endpackage

// File: rtl/mult_valid_dly.sv
// Delays operand-valid by the multiplier pipeline depth so it lines up with
// the registered product.
module mult_valid_dly
  import mult_pkg::*;
#(
  parameter int N = MULT_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  output logic valid_dly
);

  logic [N-1:0] shift_r;

  generate
    if (N == 1) begin : g_one
      // single-stage delay
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shift_r <= 1'b0;
        end else begin
          shift_r <= valid;
        end
      end
    end else begin : g_multi
      // shift chain, oldest sample at the top bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shift_r <= {N{1'b0}};
        end else begin
          shift_r <= {shift_r[N-2:0], valid};
        end
      end
    end
  endgenerate

  assign valid_dly = shift_r[N-1];

endmodule

// File: rtl/mult_accum.sv
// Accumulates a programmed number of products into a wide sum and presents
// the result on a valid/ready output; overflow of the sum is flagged sticky.
module mult_accum
  import mult_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int AW = 48,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          p_valid,
  input  logic [PW-1:0] p_in,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic [AW-1:0] sum_out,
  output logic          busy,
  output logic          ovf
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  acc_state_e    state_r, state_nxt_s;
  logic [AW-1:0] acc_r, acc_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [AW-1:0] sum_out_r, sum_nxt_s;
  logic          sum_valid_r, busy_r;
  logic          ovf_r, ovf_nxt_s;
  logic [AW:0]   add_s;

  // one extra bit captures the carry out of the accumulator width
  assign add_s = {1'b0, acc_r} + {{(AW-PW+1){1'b0}}, p_in};

  // next-state and datapath selection
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    sum_nxt_s   = sum_out_r;
    ovf_nxt_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          ovf_nxt_s = 1'b0;
          if (len != {CW{1'b0}}) begin
            acc_nxt_s   = {AW{1'b0}};
            cnt_nxt_s   = len;
            state_nxt_s = ACC;
          end else begin
            sum_nxt_s   = {AW{1'b0}};
            state_nxt_s = HOLD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (p_valid) begin
          acc_nxt_s = add_s[AW-1:0];
          cnt_nxt_s = cnt_r - CNT_ONE;
          ovf_nxt_s = ovf_r | add_s[AW];
          if (cnt_r == CNT_ONE) begin
            sum_nxt_s   = add_s[AW-1:0];
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = ACC;
          end
        end else begin
          state_nxt_s = ACC;
        end
      end
      HOLD: begin
        if (sum_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // state, datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {AW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      sum_out_r   <= {AW{1'b0}};
      sum_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      sum_out_r   <= sum_nxt_s;
      sum_valid_r <= (state_nxt_s == HOLD);
      busy_r      <= (state_nxt_s != IDLE);
      ovf_r       <= ovf_nxt_s;
    end
  end

  assign sum_valid = sum_valid_r;
  assign sum_out   = sum_out_r;
  assign busy      = busy_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_mult_accum.sv
// Directed self-checking bench for mult_accum, including a 33-bit instance
// for wrap/overflow and an end-to-end path through a registered multiplier.
module tb_mult_accum;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // main instance (AW=48)
  logic        start, p_valid_tb, sum_ready, e2e_mode;
  logic [7:0]  len;
  logic [31:0] p_in_tb;
  logic        p_valid, sum_valid, busy, ovf;
  logic [31:0] p_in;
  logic [47:0] sum_out;

  // narrow instance (AW=33)
  logic        st33, pv33, rdy33, sv33, busy33, ovf33;
  logic [7:0]  len33;
  logic [31:0] pi33;
  logic [32:0] so33;

  // registered multiplier model feeding the end-to-end path
  logic        op_valid, dly_valid;
  logic [15:0] x, y, x_r, y_r;
  logic [31:0] p_model_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r <= 16'd0; y_r <= 16'd0; p_model_r <= 32'd0;
    end else begin
      x_r <= x; y_r <= y; p_model_r <= 32'(x_r) * 32'(y_r);
    end
  end

  mult_valid_dly #(.N(MULT_LAT)) u_dly (
    .clk(clk), .rst(rst), .valid(op_valid), .valid_dly(dly_valid)
  );

  assign p_valid = e2e_mode ? dly_valid : p_valid_tb;
  assign p_in    = e2e_mode ? p_model_r : p_in_tb;

  mult_accum u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .p_valid(p_valid),
    .p_in(p_in), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum_out(sum_out), .busy(busy), .ovf(ovf)
  );

  mult_accum #(.AW(33)) u_dut33 (
    .clk(clk), .rst(rst), .start(st33), .len(len33), .p_valid(pv33),
    .p_in(pi33), .sum_valid(sv33), .sum_ready(rdy33),
    .sum_out(so33), .busy(busy33), .ovf(ovf33)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (sum_valid !== 1'b0) begin failures++; $display("FAIL reset_sum_valid: got %b want 0", sum_valid); end
    checks++; if (sum_out !== 48'd0) begin failures++; $display("FAIL reset_sum_out: got %h want 0", sum_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", busy); end
    p_valid_tb = 1'b1; p_in_tb = 32'd10;
    tick();
    p_in_tb = 32'd20;
    tick();
    checks++; if (sum_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b want 0", sum_valid); end
    p_in_tb = 32'd30;
    tick();
    p_valid_tb = 1'b0;
    checks++; if (sum_valid !== 1'b1) begin failures++; $display("FAIL basic_sum_valid: got %b want 1", sum_valid); end
    checks++; if (sum_out !== 48'd60) begin failures++; $display("FAIL basic_sum_out: got %0d want 60", sum_out); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b want 0", ovf); end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    checks++; if (sum_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_accept: got valid=%b busy=%b want 0 0", sum_valid, busy); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p_valid_tb = 1'b1; p_in_tb = 32'hFFFF_FFFF;
      tick();
      p_valid_tb = 1'b0;
      if (i < 3) begin
        checks++; if (busy !== 1'b1 || sum_valid !== 1'b0) begin failures++; $display("FAIL gap_prod%0d: got busy=%b valid=%b want 1 0", i, busy, sum_valid); end
        tick();
        checks++; if (busy !== 1'b1 || sum_valid !== 1'b0) begin failures++; $display("FAIL gap_idle%0d: got busy=%b valid=%b want 1 0", i, busy, sum_valid); end
      end
    end
    checks++; if (sum_valid !== 1'b1) begin failures++; $display("FAIL gap_sum_valid: got %b want 1", sum_valid); end
    checks++; if (sum_out !== 48'h3_FFFF_FFFC) begin failures++; $display("FAIL gap_sum_out: got %h want 3fffffffc", sum_out); end
    // hold with stray start and product
    for (int i = 0; i < 5; i++) begin
      start = (i == 1); len = 8'd2;
      p_valid_tb = (i == 2); p_in_tb = 32'd99;
      tick();
      start = 1'b0; p_valid_tb = 1'b0;
      checks++; if (sum_valid !== 1'b1 || sum_out !== 48'h3_FFFF_FFFC || busy !== 1'b1) begin failures++; $display("FAIL hold_stable%0d: got valid=%b sum=%h busy=%b want 1 3fffffffc 1", i, sum_valid, sum_out, busy); end
    end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    checks++; if (sum_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL hold_accept: got valid=%b busy=%b want 0 0", sum_valid, busy); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_start_ignored: got busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    p_valid_tb = 1'b1; p_in_tb = 32'd100;
    tick();
    p_in_tb = 32'd200;
    tick();
    p_valid_tb = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || sum_valid !== 1'b0 || sum_out !== 48'd0 || ovf !== 1'b0) begin failures++; $display("FAIL async_rst: got busy=%b valid=%b sum=%h ovf=%b want all 0", busy, sum_valid, sum_out, ovf); end
    #1 rst = 1'b0;
    tick();
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    p_valid_tb = 1'b1; p_in_tb = 32'd7;
    tick();
    p_valid_tb = 1'b0;
    checks++; if (sum_valid !== 1'b1 || sum_out !== 48'd7) begin failures++; $display("FAIL after_rst_sum: got valid=%b sum=%0d want 1 7", sum_valid, sum_out); end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  task automatic test_len_zero();
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    checks++; if (sum_valid !== 1'b1 || sum_out !== 48'd0 || busy !== 1'b1) begin failures++; $display("FAIL len0_hold: got valid=%b sum=%h busy=%b want 1 0 1", sum_valid, sum_out, busy); end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    checks++; if (sum_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL len0_accept: got valid=%b busy=%b want 0 0", sum_valid, busy); end
  endtask

  task automatic test_ovf();
    st33 = 1'b1; len33 = 8'd3;
    tick();
    st33 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pv33 = 1'b1; pi33 = 32'hFFFF_FFFF;
      tick();
    end
    pv33 = 1'b0;
    checks++; if (sv33 !== 1'b1 || so33 !== 33'h0_FFFF_FFFD) begin failures++; $display("FAIL ovf_wrap: got valid=%b sum=%h want 1 0fffffffd", sv33, so33); end
    checks++; if (ovf33 !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", ovf33); end
    rdy33 = 1'b1;
    tick();
    rdy33 = 1'b0;
    checks++; if (ovf33 !== 1'b1 || busy33 !== 1'b0) begin failures++; $display("FAIL ovf_sticky: got ovf=%b busy=%b want 1 0", ovf33, busy33); end
    st33 = 1'b1; len33 = 8'd1;
    tick();
    st33 = 1'b0;
    checks++; if (ovf33 !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", ovf33); end
    pv33 = 1'b1; pi33 = 32'd1;
    tick();
    pv33 = 1'b0;
    checks++; if (so33 !== 33'd1 || ovf33 !== 1'b0) begin failures++; $display("FAIL ovf_next_sum: got sum=%h ovf=%b want 1 0", so33, ovf33); end
    rdy33 = 1'b1;
    tick();
    rdy33 = 1'b0;
  endtask

  task automatic test_end_to_end();
    e2e_mode = 1'b1;
    start = 1'b1; len = 8'd1;
    tick();
    start = 1'b0;
    op_valid = 1'b1; x = 16'd3; y = 16'd5;
    tick();
    op_valid = 1'b0; x = 16'd0; y = 16'd0;
    for (int c = 0; c < 10 && sum_valid !== 1'b1; c++) tick();
    checks++; if (sum_valid !== 1'b1) begin failures++; $display("FAIL e2e_timeout: got valid=%b want 1", sum_valid); end
    checks++; if (sum_out !== 48'd15) begin failures++; $display("FAIL e2e_sum: got %0d want 15", sum_out); end
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    e2e_mode = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; len = 8'd0; p_valid_tb = 1'b0; p_in_tb = 32'd0; sum_ready = 1'b0;
    e2e_mode = 1'b0;
    st33 = 1'b0; len33 = 8'd0; pv33 = 1'b0; pi33 = 32'd0; rdy33 = 1'b0;
    op_valid = 1'b0; x = 16'd0; y = 16'd0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_async_reset();
    test_len_zero();
    test_ovf();
    test_end_to_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
